// File: rtl/ui_button_pkg.sv
// ui_button_pkg
// Shared definitions for the button event path: button codes, event kinds,
// sink IDs, the 8-bit queued entry layout and the dispatcher FSM states.
package ui_button_pkg;

  typedef logic [3:0] code_t;
  typedef logic [1:0] kind_t;
  typedef logic [1:0] sink_t;

  localparam code_t BTN_D0    = 4'd0;
  localparam code_t BTN_D1    = 4'd1;
  localparam code_t BTN_D2    = 4'd2;
  localparam code_t BTN_D3    = 4'd3;
  localparam code_t BTN_ENTER = 4'd4;
  localparam code_t BTN_LEFT  = 4'd5;
  localparam code_t BTN_RIGHT = 4'd6;
  localparam code_t BTN_UP    = 4'd7;
  localparam code_t BTN_DOWN  = 4'd8;

  localparam kind_t EVT_NONE    = 2'd0;
  localparam kind_t EVT_PRESS   = 2'd1;
  localparam kind_t EVT_REPEAT  = 2'd2;
  localparam kind_t EVT_RELEASE = 2'd3;

  localparam sink_t SINK_DIAL = 2'd0;
  localparam sink_t SINK_MENU = 2'd1;
  localparam sink_t SINK_CALL = 2'd2;
  localparam sink_t SINK_VOL  = 2'd3;

  // Entry layout {sink[7:6], code[5:2], kind[1:0]}
  typedef struct packed {
    sink_t sink;
    code_t code;
    kind_t kind;
  } evt_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_REPEAT
  } state_t;

  // Button level bit position to button code; bit 8 is button0, bit 0 is down.
  function automatic code_t code_of(input logic [8:0] onehot);
    code_t c;
    case (onehot)
      9'b1_0000_0000: c = BTN_D0;
      9'b0_1000_0000: c = BTN_D1;
      9'b0_0100_0000: c = BTN_D2;
      9'b0_0010_0000: c = BTN_D3;
      9'b0_0001_0000: c = BTN_ENTER;
      9'b0_0000_1000: c = BTN_LEFT;
      9'b0_0000_0100: c = BTN_RIGHT;
      9'b0_0000_0010: c = BTN_UP;
      9'b0_0000_0001: c = BTN_DOWN;
      default:        c = BTN_D0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/button_event_dispatcher_if.sv
// button_event_dispatcher_if
// Event delivery bus from the dispatcher to the four UI sinks.
//   evt_valid  [3:0] one-hot, bit n = event offered to sink n
//   evt_ready  [3:0] per-sink accept
//   evt_code   [3:0] button code of the offered event
//   evt_kind   [1:0] press / repeat / release
// master: dispatcher side, slave: sink side.
interface button_event_dispatcher_if;
  logic [3:0] evt_valid;
  logic [3:0] evt_ready;
  logic [3:0] evt_code;
  logic [1:0] evt_kind;

  modport master (output evt_valid, output evt_code, output evt_kind, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_kind, output evt_ready);
endinterface

// File: rtl/button_event_fifo.sv
// button_event_fifo
// Synchronous DEPTH x 8 event queue with combinational head read.
//   clk, reset   clock, synchronous active-high reset (flushes pointers)
//   push/wr_data enqueue request and entry; ignored when full unless popping
//   pop          dequeue the head entry
//   head         current head entry (undefined content when empty)
//   full, empty  occupancy flags
module button_event_fifo
  import ui_button_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  evt_entry_t wr_data,
  input  logic       pop,
  output evt_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr, rd_ptr;
  evt_entry_t  mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/button_event_dispatcher.sv
// button_event_dispatcher
// Converts one-hot button levels into press / auto-repeat / release events,
// queues them with the focus owner captured at enqueue, and offers the head
// entry to that sink over a valid/ready handshake.
//   clk, reset    clock, synchronous active-high reset
//   button_in     9-bit button levels, at most one high
//   focus_in      new focus owner, loaded on focus_load
//   evt           event bus (master modport)
//   overflow      sticky, set when an event is dropped on a full queue
//   overflow_clr  clears overflow (a same-cycle drop wins)
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | no button latched, waiting for a valid press
// S_HELD   | button latched, counting down to the first repeat
// S_REPEAT | button latched, counting down between repeats
module button_event_dispatcher
  import ui_button_pkg::*;
#(
  parameter int HOLD_CYCLES   = 13_500_000,
  parameter int REPEAT_CYCLES = 2_700_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [8:0]                   button_in,
  input  logic [1:0]                   focus_in,
  input  logic                         focus_load,
  button_event_dispatcher_if.master    evt,
  output logic                         overflow,
  input  logic                         overflow_clr
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  logic [8:0]    button_q, latched_q, latched_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sink_t         focus_q;
  logic          push, pop, drop, full, empty;
  code_t         push_code;
  kind_t         push_kind;
  evt_entry_t    push_entry, head;

  always_ff @(posedge clk) begin
    if (reset) begin
      button_q  <= '0;
      latched_q <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      focus_q   <= SINK_DIAL;
      overflow  <= 1'b0;
    end else begin
      // Contention leaking through as several bits is treated as no button.
      button_q  <= ((button_in & (button_in - 9'd1)) == 9'd0) ? button_in : 9'd0;
      latched_q <= latched_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (focus_load) focus_q <= focus_in;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latched_d = latched_q;
    push      = 1'b0;
    push_kind = EVT_NONE;
    push_code = code_of(latched_q);
    case (state_q)
      S_IDLE: begin
        if (button_q != 9'd0) begin
          push      = 1'b1;
          push_kind = EVT_PRESS;
          push_code = code_of(button_q);
          latched_d = button_q;
          cnt_d     = CW'(HOLD_CYCLES - 1);
          state_d   = S_HELD;
        end
      end
      default: begin
        // Release wins over a repeat falling due in the same cycle.
        if (button_q != latched_q) begin
          push      = 1'b1;
          push_kind = EVT_RELEASE;
          state_d   = S_IDLE;
        end else if (cnt_q == '0) begin
          push      = 1'b1;
          push_kind = EVT_REPEAT;
          cnt_d     = CW'(REPEAT_CYCLES - 1);
          state_d   = S_REPEAT;
        end else begin
          cnt_d     = cnt_q - CW'(1);
        end
      end
    endcase
  end

  assign push_entry = '{sink: focus_q, code: push_code, kind: push_kind};
  assign drop       = push && full && !pop;

  button_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Ready from sinks other than the head's target cannot pop.
  assign evt.evt_valid = empty ? 4'b0000 : (4'b0001 << head.sink);
  assign evt.evt_code  = empty ? 4'd0 : head.code;
  assign evt.evt_kind  = empty ? 2'd0 : head.kind;
  assign pop           = |(evt.evt_valid & evt.evt_ready);

endmodule

// File: tb/tb_button_event_dispatcher.sv
module tb_button_event_dispatcher;
  import ui_button_pkg::*;

  localparam int HOLD  = 8;
  localparam int REP   = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] code;
    logic [1:0] kind;
    int         cyc;     // -1: order only, no timing check
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] button_in = '0;
  logic [1:0] focus_in = '0;
  logic       focus_load = 1'b0;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        obs_q[$];
  ev_t        exp_q[$];

  button_event_dispatcher_if bus();

  button_event_dispatcher #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_in    (button_in),
    .focus_in     (focus_in),
    .focus_load   (focus_load),
    .evt          (bus),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted event mid-cycle; it pops on the next rising edge.
  always @(negedge clk) begin
    if (!reset && ((bus.evt_valid & bus.evt_ready) != 4'b0000))
      obs_q.push_back('{bus.evt_valid, bus.evt_code, bus.evt_kind, cyc});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic ev_t mk(input logic [3:0] v, input logic [3:0] c, input logic [1:0] k, input int t);
    ev_t e;
    e.valid = v;
    e.code  = c;
    e.kind  = k;
    e.cyc   = t;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.evt_ready = 4'b0000;
    step(3);
    checks++;
    if (bus.evt_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b want 0000", bus.evt_valid);
    end
    checks++;
    if (bus.evt_code !== 4'd0) begin
      errors++; $display("FAIL reset_code got %0d want 0", bus.evt_code);
    end
    checks++;
    if (bus.evt_kind !== 2'd0) begin
      errors++; $display("FAIL reset_kind got %0d want 0", bus.evt_kind);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow got %b want 0", overflow);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_hold_repeat();
    int  t0;
    ev_t e, o;
    bus.evt_ready = 4'b1111;
    t0 = cyc;
    button_in = 9'b0_0001_0000;
    exp_q.push_back(mk(4'b0001, BTN_ENTER, EVT_PRESS,   t0 + 2));
    exp_q.push_back(mk(4'b0001, BTN_ENTER, EVT_REPEAT,  t0 + 10));
    exp_q.push_back(mk(4'b0001, BTN_ENTER, EVT_REPEAT,  t0 + 14));
    exp_q.push_back(mk(4'b0001, BTN_ENTER, EVT_REPEAT,  t0 + 18));
    exp_q.push_back(mk(4'b0001, BTN_ENTER, EVT_RELEASE, t0 + 22));
    step(20);
    button_in = '0;
    step(10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL hold_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.valid !== e.valid || o.code !== e.code || o.kind !== e.kind || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL hold_event got v=%b c=%0d k=%0d t=%0d want v=%b c=%0d k=%0d t=%0d",
                 o.valid, o.code, o.kind, o.cyc - t0, e.valid, e.code, e.kind, e.cyc - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_focus();
    int  t0;
    ev_t e, o;
    bus.evt_ready = 4'b0000;
    focus_in = 2'd1;
    focus_load = 1'b1;
    step(1);
    focus_load = 1'b0;
    step(1);
    t0 = cyc;
    button_in = 9'b0_0100_0000;
    exp_q.push_back(mk(4'b0010, BTN_D2, EVT_PRESS,   t0 + 8));
    exp_q.push_back(mk(4'b1000, BTN_D2, EVT_RELEASE, t0 + 9));
    step(2);
    focus_in = 2'd3;
    focus_load = 1'b1;
    step(1);
    focus_load = 1'b0;
    button_in = '0;
    step(3);
    bus.evt_ready = 4'b1101;
    step(1);
    checks++;
    if (bus.evt_valid !== 4'b0010 || bus.evt_code !== BTN_D2 || bus.evt_kind !== EVT_PRESS) begin
      errors++;
      $display("FAIL focus_hold_stable got v=%b c=%0d k=%0d want v=0010 c=2 k=1",
               bus.evt_valid, bus.evt_code, bus.evt_kind);
    end
    step(1);
    bus.evt_ready = 4'b1111;
    step(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL focus_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.valid !== e.valid || o.code !== e.code || o.kind !== e.kind || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL focus_event got v=%b c=%0d k=%0d t=%0d want v=%b c=%0d k=%0d t=%0d",
                 o.valid, o.code, o.kind, o.cyc - t0, e.valid, e.code, e.kind, e.cyc - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
    focus_in = 2'd0;
    focus_load = 1'b1;
    step(1);
    focus_load = 1'b0;
    step(1);
  endtask

  task automatic test_overflow();
    ev_t e, o;
    bus.evt_ready = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) begin
        exp_q.push_back(mk(4'b0001, BTN_D1, EVT_PRESS,   -1));
        exp_q.push_back(mk(4'b0001, BTN_D1, EVT_RELEASE, -1));
      end
      button_in = 9'b0_1000_0000;
      step(2);
      button_in = '0;
      step(2);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %b want 1", overflow);
    end
    checks++;
    if (bus.evt_valid !== 4'b0001 || bus.evt_code !== BTN_D1 || bus.evt_kind !== EVT_PRESS) begin
      errors++;
      $display("FAIL ovf_head got v=%b c=%0d k=%0d want v=0001 c=1 k=1",
               bus.evt_valid, bus.evt_code, bus.evt_kind);
    end
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", overflow);
    end
    bus.evt_ready = 4'b1111;
    step(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_drain_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.valid !== e.valid || o.code !== e.code || o.kind !== e.kind) begin
        errors++;
        $display("FAIL ovf_drain got v=%b c=%0d k=%0d want v=%b c=%0d k=%0d",
                 o.valid, o.code, o.kind, e.valid, e.code, e.kind);
      end
    end
    exp_q.delete();
    obs_q.delete();

    // Refill to exactly full, then push and pop together, then drop with clear.
    bus.evt_ready = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(4'b0001, BTN_D1, EVT_PRESS,   -1));
      exp_q.push_back(mk(4'b0001, BTN_D1, EVT_RELEASE, -1));
      button_in = 9'b0_1000_0000;
      step(2);
      button_in = '0;
      step(2);
    end
    button_in = 9'b0_1000_0000;
    exp_q.push_back(mk(4'b0001, BTN_D1, EVT_PRESS, -1));
    step(1);
    bus.evt_ready = 4'b0001;
    step(1);
    bus.evt_ready = 4'b0000;
    button_in = '0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL full_push_pop overflow got %b want 0", overflow);
    end
    step(1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL drop_with_clr overflow got %b want 1", overflow);
    end
    bus.evt_ready = 4'b1111;
    step(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_drain_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.valid !== e.valid || o.code !== e.code || o.kind !== e.kind) begin
        errors++;
        $display("FAIL full_drain got v=%b c=%0d k=%0d want v=%b c=%0d k=%0d",
                 o.valid, o.code, o.kind, e.valid, e.code, e.kind);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_invalid();
    bus.evt_ready = 4'b1111;
    button_in = 9'b0_0000_0011;
    step(12);
    checks++;
    if (obs_q.size() != 0 || bus.evt_valid !== 4'b0000) begin
      errors++;
      $display("FAIL invalid_idle got events=%0d v=%b want events=0 v=0000", obs_q.size(), bus.evt_valid);
    end
    button_in = '0;
    step(2);
    obs_q.delete();
  endtask

  task automatic test_switch();
    int  t0;
    ev_t e, o;
    bus.evt_ready = 4'b1111;
    t0 = cyc;
    button_in = 9'b0_0000_0010;
    exp_q.push_back(mk(4'b0001, BTN_UP,   EVT_PRESS,   t0 + 2));
    exp_q.push_back(mk(4'b0001, BTN_UP,   EVT_RELEASE, t0 + 5));
    exp_q.push_back(mk(4'b0001, BTN_DOWN, EVT_PRESS,   t0 + 6));
    exp_q.push_back(mk(4'b0001, BTN_DOWN, EVT_RELEASE, t0 + 8));
    step(3);
    button_in = 9'b0_0000_0001;
    step(3);
    button_in = '0;
    step(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL switch_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.valid !== e.valid || o.code !== e.code || o.kind !== e.kind || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL switch_event got v=%b c=%0d k=%0d t=%0d want v=%b c=%0d k=%0d t=%0d",
                 o.valid, o.code, o.kind, o.cyc - t0, e.valid, e.code, e.kind, e.cyc - t0);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_flush();
    int  d;
    ev_t e, o;
    bus.evt_ready = 4'b0000;
    button_in = 9'b1_0000_0000;
    step(2);
    button_in = '0;
    step(2);
    button_in = 9'b0_0010_0000;
    step(3);
    checks++;
    if (bus.evt_valid !== 4'b0001 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got v=%b ovf=%b want v=0001 ovf=1", bus.evt_valid, overflow);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (bus.evt_valid !== 4'b0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush got v=%b ovf=%b want v=0000 ovf=0", bus.evt_valid, overflow);
    end
    bus.evt_ready = 4'b1111;
    step(1);
    reset = 1'b0;
    d = cyc;
    exp_q.push_back(mk(4'b0001, BTN_D3, EVT_PRESS,   d + 2));
    exp_q.push_back(mk(4'b0001, BTN_D3, EVT_RELEASE, d + 5));
    step(3);
    button_in = '0;
    step(5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL post_reset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.valid !== e.valid || o.code !== e.code || o.kind !== e.kind || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL post_reset_event got v=%b c=%0d k=%0d t=%0d want v=%b c=%0d k=%0d t=%0d",
                 o.valid, o.code, o.kind, o.cyc - d, e.valid, e.code, e.kind, e.cyc - d);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    bus.evt_ready = 4'b0000;
    test_reset();
    test_hold_repeat();
    test_focus();
    test_overflow();
    test_invalid();
    test_switch();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_dispatcher.md
# button_event_dispatcher

Turns the one-hot button levels from the button contention stage into discrete press, auto-repeat and release events. Events are queued in a small FIFO and delivered by valid/ready handshake to one of four UI consumers: dialer, menu, call control and volume. The consumer that receives an event is the one holding focus when the event was generated. This block sits between button conditioning and all UI state machines.

## Interface
Parameters:
- HOLD_CYCLES, 13_500_000: cycles from a press event to the first repeat event (0.5 s at 27 MHz); minimum 2.
- REPEAT_CYCLES, 2_700_000: cycles between consecutive repeat events (100 ms); minimum 2.
- FIFO_DEPTH, 4: event queue entries; power of two, minimum 2.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- button_in  in  9  button levels, at most one bit high; bit 8 = button0, 7 = button1, 6 = button2, 5 = button3, 4 = enter, 3 = left, 2 = right, 1 = up, 0 = down.
- focus_in  in  2  new focus owner (0 dialer, 1 menu, 2 call control, 3 volume).
- focus_load  in  1  loads focus_in into the focus register.
- evt_valid  out  4  one-hot; bit n high = an event is offered to sink n.
- evt_ready  in  4  per-sink accept.
- evt_code  out  4  button code: 0–3 digits, 4 enter, 5 left, 6 right, 7 up, 8 down.
- evt_kind  out  2  event kind: 1 press, 2 repeat, 3 release.
- overflow  out  1  sticky flag; set when an event is dropped.
- overflow_clr  in  1  clears overflow.

## Operation
- Input stage: button_in is registered into button_q. If more than one bit is set, it is treated as all-zero.
- Three-state FSM: IDLE, HELD, REPEAT.
  - IDLE, button_q nonzero: enqueue press(code), latch code, load the counter with HOLD_CYCLES-1, go to HELD.
  - HELD or REPEAT, counter reaches 0: enqueue repeat(code), reload the counter with REPEAT_CYCLES-1, go to REPEAT.
  - HELD or REPEAT, button_q not equal to the latched one-hot value (zero or a different button): enqueue release(latched code), go to IDLE. A different button then produces its press from IDLE on the next cycle.
  - Release takes priority over a repeat due in the same cycle.
- Focus register:
  - Reset value 0.
  - Updated on focus_load.
  - Each enqueued entry stores {sink, code, kind}, with sink = focus register value at enqueue. Events already queued keep their original sink after a focus change.
- Output:
  - When the FIFO is not empty, evt_valid[head.sink] = 1 and all other bits = 0.
  - evt_code and evt_kind show the head entry.
  - Pop on evt_valid[s] & evt_ready[s]. evt_ready bits of non-targeted sinks are ignored.
- Full FIFO with no pop that cycle: the new event is dropped and overflow is set. Push and pop in the same cycle while full: both succeed.
- overflow_clr and a new drop in the same cycle: overflow stays 1.
- Counter width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). The down-counter never wraps.

## Timing
- Reset values: evt_valid = 0, evt_code = 0, evt_kind = 0, overflow = 0. FSM is IDLE, FIFO is empty, focus = 0.
- Reset mid-operation flushes queued events. No release is emitted for a button held through reset; it produces a fresh press afterwards.
- button_in rises in cycle 0: button_q valid in cycle 1, press enqueued at the end of cycle 1, evt_valid high in cycle 2. Total latency is 2 cycles into an empty FIFO.
- First repeat: enqueued HOLD_CYCLES cycles after the press enqueue. Subsequent repeats: every REPEAT_CYCLES cycles.
- Release: enqueued 1 cycle after button_q drops; visible on the outputs the following cycle.
- Handshake:
  - Outputs stay stable while evt_valid is high and evt_ready is low.
  - With a back-to-back evt_ready from the sink, one event is popped per cycle.
  - The next head entry appears the cycle after a pop.
- focus_load in cycle k affects events enqueued at the end of cycle k+1 and later.

## Structure
- Shared package ui_button_pkg holds:
  - button code constants (BTN_D0..BTN_DOWN);
  - event kind constants (EVT_PRESS=1, EVT_REPEAT=2, EVT_RELEASE=3);
  - sink IDs (SINK_DIAL, SINK_MENU, SINK_CALL, SINK_VOL);
  - the 8-bit entry layout {sink[7:6], code[5:2], kind[1:0]}.
- Sub-module button_event_fifo: synchronous FIFO (FIFO_DEPTH × 8), registered pointers, combinational head read, full/empty flags, same-cycle push/pop.

## Test plan
- HOLD_CYCLES = 8, REPEAT_CYCLES = 4; enter (bit 4) held 20 cycles, sink always ready:
  - press code 4 in cycle 2;
  - repeats at cycles 10, 14, 18;
  - release code 4 two cycles after the drop;
  - all events on evt_valid = 4'b0001.
- Press digit 2 with focus = 1, then focus_load to 3 before the sink is ready → press goes to sink 1 (0010); release goes to sink 3 (1000).
- evt_ready held low, six press/release pairs of button1 → first four queued, overflow = 1, later events dropped; on draining, codes and kinds come out in order.
- button_in = 9'b000000011 (two bits high) → treated as idle, no event for 10 cycles.
- Direct switch from up (code 7) to down (code 8) with no idle gap → release 7, then press 8 one cycle later.
- Reset asserted with two queued events and a button held → evt_valid = 0 next cycle, overflow = 0; after reset, a fresh press arrives 2 cycles after deassertion.
